crypto_stream_ctrl: RTL and testbench
=====================================

// Module: crypto_stream_ctrl
// PURPOSE
//  Sequencer that streams a block of bytes from data memory through the shared
//  combinational crypto unit and writes the results back to data memory. Sits
//  beside the cpu control unit and owns the crypto unit and memory ports while busy.
//  The CPU programs src/dst/len/key and pulses start; done pulses on completion.
// PARAMETERS
//  DATA_W      8   byte width of data, key and crypto operands
//  ADDR_W      8   data-memory address width; addresses wrap modulo 2**ADDR_W
//  KEY_ROTATE  1   1: key rotates left 1 bit after each byte; 0: fixed key
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       synchronous, active-high reset
//  start        in   1       1-cycle request; accepted only in IDLE
//  abort        in   1       stop the current block; highest priority after reset
//  src_addr     in   ADDR_W  first source byte address
//  dst_addr     in   ADDR_W  first destination byte address
//  len          in   ADDR_W  byte count (0 allowed)
//  key          in   DATA_W  initial key
//  busy         out  1       high from the cycle after acceptance until DONE
//  done         out  1       1-cycle pulse: block finished or aborted
//  aborted      out  1       valid with done: 1 if ended by abort
//  mem_rd_en    out  1       read strobe; data returned next cycle
//  mem_rd_addr  out  ADDR_W  read address
//  mem_rd_data  in   DATA_W  read data, 1-cycle synchronous latency
//  mem_wr_en    out  1       write strobe
//  mem_wr_addr  out  ADDR_W  write address
//  mem_wr_data  out  DATA_W  write data
//  crypto_in    out  DATA_W  operand to the crypto unit
//  crypto_key   out  DATA_W  key to the crypto unit
//  crypto_out   in   DATA_W  combinational crypto result
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, aborted, mem_rd_en and mem_wr_en = 0; all
//   address/data/crypto outputs = 0. Reset in any state returns to IDLE and
//   drops all strobes in the same edge. No partial write is ever issued.
//  States: IDLE -> READ -> WAIT -> XFORM -> WRITE -> (READ | DONE) -> IDLE.
//   IDLE:  on start, latch src, dst, len and key into counters; go to READ,
//          or to DONE if len==0 (no memory access).
//   READ:  mem_rd_en=1, mem_rd_addr=src_ptr.
//   WAIT:  capture mem_rd_data into data_reg.
//   XFORM: crypto_in=data_reg, crypto_key=key_reg; register crypto_out.
//   WRITE: mem_wr_en=1, mem_wr_addr=dst_ptr, mem_wr_data=result; src_ptr++,
//          dst_ptr++, remaining--, key_reg=rotl(key_reg,1) if KEY_ROTATE;
//          go to DONE if remaining was 1, else to READ.
//   DONE:  done=1 for exactly one cycle; busy=0; go to IDLE.
//  Throughput is 4 cycles/byte. Latency from start to done = 4*len + 2 cycles
//   (len=0: done 2 cycles after start).
//  Pointer arithmetic is modulo 2**ADDR_W: address 0xFF increments to 0x00.
//  start while busy is ignored, with no queueing. If start and abort are both
//   high in IDLE, abort wins and the request is dropped.
//  abort in READ/WAIT/XFORM/WRITE: the next state is DONE with aborted=1. A write
//   strobed in the same cycle as abort completes; the byte in flight is not written.
//  Overlapping src/dst is allowed. Bytes are processed strictly in ascending order.
//  crypto_in and crypto_key hold their last values outside XFORM.
// STRUCTURE
//  Shared include crypto_defs.vh: state encodings (S_IDLE..S_DONE, 3 bits) and
//   the DATA_W and ADDR_W defaults, shared with the cpu control unit.
//  Single FSM plus counters in one module; no sub-module is required.
// TESTING
//  1. len=1, src=0x10 holds 0x41 ('A'), key=0x5A, dst=0x20 -> mem[0x20]=0x1B,
//     done 6 cycles after start, aborted=0.
//  2. len=3, key=0x01, KEY_ROTATE=1, src bytes 00 00 00 -> dst bytes 01 02 04;
//     done at cycle 14.
//  3. len=0 -> no mem_rd_en or mem_wr_en ever asserted; done 2 cycles after start.
//  4. src=0xFE, dst=0xFF, len=3 -> reads from FE, FF, 00; writes to FF, 00, 01.
//  5. abort in the second READ of a len=4 block -> exactly 1 write, done with
//     aborted=1; a start during busy is ignored.
//  6. reset asserted in XFORM -> all outputs 0 at the next edge; a new start
//     runs normally.

Source files
------------

// File: rtl/crypto_stream_ctrl_pkg.sv
// Shared definitions for the crypto stream sequencer: FSM state encoding
// and default operand widths.
package crypto_stream_ctrl_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_XFORM = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/crypto_stream_ctrl.sv
// Streams len bytes from src through the external combinational crypto unit
// into dst, one byte every four cycles, with abort and synchronous reset.
module crypto_stream_ctrl
  import crypto_stream_ctrl_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter bit KEY_ROTATE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] key,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic [DATA_W-1:0] crypto_in,
  output logic [DATA_W-1:0] crypto_key,
  input  logic [DATA_W-1:0] crypto_out
);

  state_t            state;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [ADDR_W-1:0] remaining;
  logic [DATA_W-1:0] key_reg;
  logic              abort_flag;

  // Outputs are registered from the next state, so each strobe lines up with
  // the state it belongs to; done/aborted trail the DONE state by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      src_ptr     <= '0;
      dst_ptr     <= '0;
      remaining   <= '0;
      key_reg     <= '0;
      abort_flag  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      crypto_in   <= '0;
      crypto_key  <= '0;
    end else begin
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            src_ptr    <= src_addr;
            dst_ptr    <= dst_addr;
            remaining  <= len;
            key_reg    <= key;
            abort_flag <= 1'b0;
            if (len == '0) begin
              state <= S_DONE;
              busy  <= 1'b0;
            end else begin
              state       <= S_READ;
              busy        <= 1'b1;
              mem_rd_en   <= 1'b1;
              mem_rd_addr <= src_addr;
            end
          end
        end

        S_READ: begin
          if (abort) begin
            state      <= S_DONE;
            busy       <= 1'b0;
            abort_flag <= 1'b1;
          end else begin
            state <= S_WAIT;
          end
        end

        // crypto_in doubles as the captured read data for the XFORM cycle.
        S_WAIT: begin
          if (abort) begin
            state      <= S_DONE;
            busy       <= 1'b0;
            abort_flag <= 1'b1;
          end else begin
            state      <= S_XFORM;
            crypto_in  <= mem_rd_data;
            crypto_key <= key_reg;
          end
        end

        S_XFORM: begin
          if (abort) begin
            state      <= S_DONE;
            busy       <= 1'b0;
            abort_flag <= 1'b1;
          end else begin
            state       <= S_WRITE;
            mem_wr_en   <= 1'b1;
            mem_wr_addr <= dst_ptr;
            mem_wr_data <= crypto_out;
          end
        end

        // The write strobed this cycle lands regardless of abort.
        S_WRITE: begin
          src_ptr   <= src_ptr + ADDR_W'(1);
          dst_ptr   <= dst_ptr + ADDR_W'(1);
          remaining <= remaining - ADDR_W'(1);
          if (KEY_ROTATE) begin
            key_reg <= {key_reg[DATA_W-2:0], key_reg[DATA_W-1]};
          end
          if (abort) begin
            state      <= S_DONE;
            busy       <= 1'b0;
            abort_flag <= 1'b1;
          end else if (remaining == ADDR_W'(1)) begin
            state <= S_DONE;
            busy  <= 1'b0;
          end else begin
            state       <= S_READ;
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= src_ptr + ADDR_W'(1);
          end
        end

        S_DONE: begin
          state   <= S_IDLE;
          done    <= 1'b1;
          aborted <= abort_flag;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crypto_stream_ctrl.sv
// Scoreboard bench for crypto_stream_ctrl: a byte-level reference model queues
// expected reads, writes and done events; a negedge monitor pops and compares.
module tb_crypto_stream_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] src_addr = '0;
  logic [7:0] dst_addr = '0;
  logic [7:0] len = '0;
  logic [7:0] key = '0;
  logic       busy, done, aborted;
  logic       mem_rd_en, mem_wr_en;
  logic [7:0] mem_rd_addr, mem_wr_addr, mem_wr_data;
  logic [7:0] mem_rd_data = '0;
  logic [7:0] crypto_in, crypto_key, crypto_out;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];

  logic [7:0]  exp_rd[$];
  logic [15:0] exp_wr[$];
  int          exp_done_cyc[$];
  bit          exp_done_ab[$];

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  crypto_stream_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .key(key),
    .busy(busy), .done(done), .aborted(aborted),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .crypto_in(crypto_in), .crypto_key(crypto_key), .crypto_out(crypto_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // The crypto unit is a plain byte XOR with the key.
  assign crypto_out = crypto_in ^ crypto_key;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every strobe or done the DUT shows must match the queue head.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_rd_en) begin
        if (exp_rd.size() == 0) checkOutput("rd_unexpected", 1, 0);
        else checkOutput("rd_addr", mem_rd_addr, exp_rd.pop_front());
      end
      if (mem_wr_en) begin
        if (exp_wr.size() == 0) checkOutput("wr_unexpected", 1, 0);
        else checkOutput("wr_addr_data", {mem_wr_addr, mem_wr_data}, exp_wr.pop_front());
      end
      if (done) begin
        if (exp_done_cyc.size() == 0) checkOutput("done_unexpected", 1, 0);
        else begin
          checkOutput("done_cycle", cyc, exp_done_cyc.pop_front());
          checkOutput("done_aborted", aborted, exp_done_ab.pop_front());
          checkOutput("done_busy", busy, 0);
        end
      end else if (aborted) begin
        checkOutput("aborted_stray", 1, 0);
      end
    end
  end

  task automatic checkAllZero(input string name);
    checkOutput(name, {busy, done, aborted, mem_rd_en, mem_wr_en, mem_rd_addr,
                       mem_wr_addr, mem_wr_data, crypto_in, crypto_key}, 0);
  endtask

  task automatic preset(input logic [7:0] a, input logic [7:0] v);
    mem[a] <= v;
    ref_mem[a] = v;
  endtask

  // One block: model the expected traffic, then drive start plus optional
  // mid-block abort / ignored start / reset at cycle offsets from start.
  task automatic applyStimulus(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                               input logic [7:0] k, input int ab_t, input int bs_t, input int rs_t);
    int c0, nrd, nwr, tcut, last, budget;
    logic [7:0] sa, da, kj, r;
    logic [15:0] kk;
    @(posedge clk); #1;
    start = 1'b1; src_addr = s; dst_addr = d; len = l; key = k;
    c0 = cyc;
    tcut = (ab_t > 0) ? ab_t : rs_t;
    if (tcut > 0) begin
      nrd = (tcut - 1) / 4 + 1;
      nwr = (tcut - 1) / 4 + (((tcut - 1) % 4 == 3) ? 1 : 0);
    end else begin
      nrd = int'(l);
      nwr = int'(l);
    end
    for (int j = 0; j < nrd; j++) begin
      sa = s + 8'(j);
      exp_rd.push_back(sa);
    end
    for (int j = 0; j < nwr; j++) begin
      sa = s + 8'(j);
      da = d + 8'(j);
      kk = {k, k} << (j % 8);
      kj = kk[15:8];
      r = ref_mem[sa] ^ kj;
      ref_mem[da] = r;
      exp_wr.push_back({da, r});
    end
    if (rs_t == 0) begin
      exp_done_cyc.push_back((ab_t > 0) ? c0 + ab_t + 2 : c0 + 4 * int'(l) + 2);
      exp_done_ab.push_back(ab_t > 0);
    end
    last = ab_t;
    if (bs_t > last) last = bs_t;
    if (rs_t > last) last = rs_t;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 1; t <= last; t++) begin
      start = (t == bs_t);
      abort = (t == ab_t);
      reset = (t == rs_t);
      if (t == bs_t) begin
        src_addr = 8'($urandom); len = 8'($urandom_range(1, 5));
        checkOutput("busy_during_block", busy, 1);
      end
      @(posedge clk); #1;
      if (t == rs_t) checkAllZero("reset_mid_block");
    end
    start = 1'b0; abort = 1'b0; reset = 1'b0;
    budget = 200;
    while (exp_done_cyc.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (exp_done_cyc.size() != 0) begin
      checkOutput("done_timeout", 1, 0);
      exp_done_cyc.delete(); exp_done_ab.delete();
    end
    #1;
  endtask

  initial begin
    int l, ab, bs, bad;
    for (int i = 0; i < 256; i++) preset(8'(i), 8'($urandom));
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset_state");
    reset = 1'b0;

    preset(8'h10, 8'h41);
    applyStimulus(8'h10, 8'h20, 8'd1, 8'h5A, 0, 0, 0);
    checkOutput("t1_dst_byte", mem[8'h20], 8'h1B);

    for (int i = 0; i < 3; i++) preset(8'(8'h30 + i), 8'h00);
    applyStimulus(8'h30, 8'h40, 8'd3, 8'h01, 0, 0, 0);
    checkOutput("t2_dst_bytes", {mem[8'h40], mem[8'h41], mem[8'h42]}, 24'h010204);

    applyStimulus(8'h55, 8'h66, 8'd0, 8'h77, 0, 0, 0);
    applyStimulus(8'hFE, 8'hFF, 8'd3, 8'h3C, 0, 0, 0);
    applyStimulus(8'h80, 8'h90, 8'd4, 8'hA5, 5, 2, 0);
    applyStimulus(8'hA0, 8'hB0, 8'd2, 8'h11, 0, 0, 3);
    applyStimulus(8'hC0, 8'hC8, 8'd2, 8'h81, 0, 0, 0);

    // start together with abort while idle must be dropped
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; len = 8'd2;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("idle_abort_drop", busy, 0);

    for (int n = 0; n < 25; n++) begin
      l = $urandom_range(0, 8);
      ab = (l > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 4 * l) : 0;
      bs = (l > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, (ab > 0) ? ab : 4 * l) : 0;
      applyStimulus(8'($urandom), 8'($urandom), 8'(l), 8'($urandom), ab, bs, 0);
    end

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rd_queue_empty", exp_rd.size(), 0);
    checkOutput("wr_queue_empty", exp_wr.size(), 0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    checkOutput("final_memory", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
